// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline register between CPU stages: two-entry skid buffer (main M + skid S)
// with a valid/ready handshake, synchronous flush to bubbles, and control gating on bubbles.
// Latency: 1 cycle from accept to output when EMPTY, or when ONE with a consume in the same cycle.
// Backpressure: absorbs one extra entry into S after out_ready drops. in_ready comes from registered state only.
// Ports:
//   clk, clrn        clock (rising edge) and asynchronous active-low reset
//   in_valid/ready   upstream handshake. in_ready = not full.
//   in_ctl/alu/b/rn  entry fields presented upstream
//   flush            synchronous kill of all held entries (an accept in the same cycle is dropped)
//   out_valid/ready  downstream handshake. Outputs are driven directly from M.
//   out_ctl          M.ctl gated by out_valid so a bubble never writes memory or the register file
//   out_alu/b/rn     M data fields. They hold their last value while no entry is valid.
//   count            occupancy 0..2 (the state encoding)
module pipe_elastic_reg #(
  parameter int DW   = 32,
  parameter int NCTL = 3,
  parameter int RNW  = 5
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NCTL-1:0] in_ctl,
  input  logic [DW-1:0]   in_alu,
  input  logic [DW-1:0]   in_b,
  input  logic [RNW-1:0]  in_rn,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NCTL-1:0] out_ctl,
  output logic [DW-1:0]   out_alu,
  output logic [DW-1:0]   out_b,
  output logic [RNW-1:0]  out_rn,
  output logic [1:0]      count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [NCTL-1:0] ctl;
    logic [DW-1:0]   alu;
    logic [DW-1:0]   b;
    logic [RNW-1:0]  rn;
  } entry_t;

  state_t state_q, state_d;
  entry_t m_q, m_d, s_q, s_d;
  entry_t in_ent;
  logic   accept, consume;

  assign in_ent    = {in_ctl, in_alu, in_b, in_rn};
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          m_d     = in_ent;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          m_d = in_ent;
        end else if (accept) begin
          s_d     = in_ent;
          state_d = TWO;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a drain of M into S's slot can occur
        if (consume) begin
          m_d     = s_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over everything: any same-cycle accept is discarded. Only ctl is
    // cleared so stale data cannot become a side effect. Data fields keep their values.
    if (flush) begin
      state_d = EMPTY;
      m_d     = m_q;
      s_d     = s_q;
      m_d.ctl = '0;
      s_d.ctl = '0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  assign out_ctl = m_q.ctl & {NCTL{out_valid}};
  assign out_alu = m_q.alu;
  assign out_b   = m_q.b;
  assign out_rn  = m_q.rn;
  assign count   = state_q;

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Bench for pipe_elastic_reg: a default-width and a wide instance share one stimulus stream.
// The reference model is a FIFO queue of at most two entries.
// Expected narrow outputs are the low slices of the wide entries.
module tb_pipe_elastic_reg;

  logic clk = 1'b0;
  logic clrn;
  logic in_valid, out_ready, flush;
  logic [4:0]  in_ctl;
  logic [63:0] in_alu, in_b;
  logic [5:0]  in_rn;

  // default-parameter instance
  logic        n_in_ready, n_out_valid;
  logic [2:0]  n_out_ctl;
  logic [31:0] n_out_alu, n_out_b;
  logic [4:0]  n_out_rn;
  logic [1:0]  n_count;

  // wide instance
  logic        w_in_ready, w_out_valid;
  logic [4:0]  w_out_ctl;
  logic [63:0] w_out_alu, w_out_b;
  logic [5:0]  w_out_rn;
  logic [1:0]  w_count;

  always #5 clk = ~clk;

  pipe_elastic_reg u_n (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_ctl(in_ctl[2:0]), .in_alu(in_alu[31:0]), .in_b(in_b[31:0]), .in_rn(in_rn[4:0]),
    .flush(flush), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_ctl(n_out_ctl), .out_alu(n_out_alu), .out_b(n_out_b), .out_rn(n_out_rn),
    .count(n_count)
  );

  pipe_elastic_reg #(.DW(64), .NCTL(5), .RNW(6)) u_w (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_ctl(in_ctl), .in_alu(in_alu), .in_b(in_b), .in_rn(in_rn),
    .flush(flush), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_ctl(w_out_ctl), .out_alu(w_out_alu), .out_b(w_out_b), .out_rn(w_out_rn),
    .count(w_count)
  );

  typedef struct packed {
    logic [4:0]  ctl;
    logic [63:0] alu;
    logic [63:0] b;
    logic [5:0]  rn;
  } ent_t;

  ent_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("n_count",     64'(n_count),     64'(n));
    chk("w_count",     64'(w_count),     64'(n));
    chk("n_in_ready",  64'(n_in_ready),  64'(n < 2));
    chk("w_in_ready",  64'(w_in_ready),  64'(n < 2));
    chk("n_out_valid", 64'(n_out_valid), 64'(n > 0));
    chk("w_out_valid", 64'(w_out_valid), 64'(n > 0));
    if (n > 0) begin
      chk("n_out_ctl", 64'(n_out_ctl), 64'(q[0].ctl[2:0]));
      chk("w_out_ctl", 64'(w_out_ctl), 64'(q[0].ctl));
      chk("n_out_alu", 64'(n_out_alu), 64'(q[0].alu[31:0]));
      chk("w_out_alu", w_out_alu,      q[0].alu);
      chk("n_out_b",   64'(n_out_b),   64'(q[0].b[31:0]));
      chk("w_out_b",   w_out_b,        q[0].b);
      chk("n_out_rn",  64'(n_out_rn),  64'(q[0].rn[4:0]));
      chk("w_out_rn",  64'(w_out_rn),  64'(q[0].rn));
    end else begin
      chk("n_out_ctl_bubble", 64'(n_out_ctl), 64'd0);
      chk("w_out_ctl_bubble", 64'(w_out_ctl), 64'd0);
    end
  endtask

  // Drive one cycle from a negedge, update the model at the rising edge, and check at the next negedge.
  task automatic cyc(input logic v, input logic [4:0] c, input logic [63:0] a, input logic [63:0] b,
                     input logic [5:0] r, input logic ordy, input logic fl);
    logic acc, cons;
    ent_t e;
    in_valid = v; in_ctl = c; in_alu = a; in_b = b; in_rn = r; out_ready = ordy; flush = fl;
    @(posedge clk);
    acc  = v && (q.size() < 2);
    cons = ordy && (q.size() > 0);
    if (cons) void'(q.pop_front());
    if (fl) q.delete();
    else if (acc) begin
      e = '{ctl: c, alu: a, b: b, rn: r};
      q.push_back(e);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic check_reset_zero();
    chk("rst_n_count",  64'(n_count),     64'd0);
    chk("rst_w_count",  64'(w_count),     64'd0);
    chk("rst_n_valid",  64'(n_out_valid), 64'd0);
    chk("rst_w_valid",  64'(w_out_valid), 64'd0);
    chk("rst_n_ready",  64'(n_in_ready),  64'd1);
    chk("rst_w_ready",  64'(w_in_ready),  64'd1);
    chk("rst_n_ctl",    64'(n_out_ctl),   64'd0);
    chk("rst_w_ctl",    64'(w_out_ctl),   64'd0);
    chk("rst_n_alu",    64'(n_out_alu),   64'd0);
    chk("rst_w_alu",    w_out_alu,        64'd0);
    chk("rst_n_b",      64'(n_out_b),     64'd0);
    chk("rst_w_b",      w_out_b,          64'd0);
    chk("rst_n_rn",     64'(n_out_rn),    64'd0);
    chk("rst_w_rn",     64'(w_out_rn),    64'd0);
  endtask

  initial begin
    clrn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_ctl = '0; in_alu = '0; in_b = '0; in_rn = '0;
    @(negedge clk);
    check_reset_zero();
    clrn = 1'b1;
    @(negedge clk);
    check_all();

    // Streaming: alu=1..4 back to back, with full-width upper bits and rn=63 on the wide instance.
    for (int i = 1; i <= 4; i++)
      cyc(1'b1, 5'b00101, {32'hFFFF_FFFF, 32'(i)}, 64'hA5A5_0000_0000_0000 + 64'(i), 6'd63, 1'b1, 1'b0);
    cyc(1'b0, 5'b0, '0, '0, '0, 1'b1, 1'b0);

    // Backpressure: 10 lands, out_ready drops, 11 goes to S, 12 waits upstream, then everything drains in order.
    cyc(1'b1, 5'b00001, 64'd10, 64'd100, 6'd10, 1'b1, 1'b0);
    cyc(1'b1, 5'b00010, 64'd11, 64'd110, 6'd11, 1'b0, 1'b0);
    cyc(1'b1, 5'b00011, 64'd12, 64'd120, 6'd12, 1'b0, 1'b0);
    cyc(1'b1, 5'b00011, 64'd12, 64'd120, 6'd12, 1'b0, 1'b0);
    cyc(1'b1, 5'b00011, 64'd12, 64'd120, 6'd12, 1'b1, 1'b0);
    cyc(1'b1, 5'b00011, 64'd12, 64'd120, 6'd12, 1'b1, 1'b0);
    cyc(1'b0, 5'b0, '0, '0, '0, 1'b1, 1'b0);

    // Flush with a full buffer of all-ones ctl.
    cyc(1'b1, 5'b11111, 64'hFFFF_FFFF_0000_0001, 64'd1, 6'd63, 1'b0, 1'b0);
    cyc(1'b1, 5'b11111, 64'hFFFF_FFFF_0000_0002, 64'd2, 6'd62, 1'b0, 1'b0);
    cyc(1'b0, 5'b0, '0, '0, '0, 1'b0, 1'b1);

    // Flush with a simultaneous accept: 0x55 must never surface.
    cyc(1'b1, 5'b00111, 64'h20, 64'h20, 6'd1, 1'b0, 1'b0);
    cyc(1'b1, 5'b00111, 64'h55, 64'h55, 6'd5, 1'b0, 1'b1);
    cyc(1'b0, 5'b0, '0, '0, '0, 1'b1, 1'b0);
    chk("no_0x55", 64'(n_out_valid && n_out_alu == 32'h55), 64'd0);

    // Asynchronous reset mid-transfer with count=2.
    cyc(1'b1, 5'b00111, 64'h31, 64'h31, 6'd3, 1'b0, 1'b0);
    cyc(1'b1, 5'b00111, 64'h32, 64'h32, 6'd3, 1'b0, 1'b0);
    #2 clrn = 1'b0;
    #1 q.delete();
    check_reset_zero();
    @(negedge clk);
    clrn = 1'b1;
    cyc(1'b1, 5'b00110, 64'h77, 64'h88, 6'd7, 1'b0, 1'b0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
          6'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before the bench completed");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_elastic_reg.md
# pipe_elastic_reg

Parametrised elastic pipeline register for inter-stage boundaries (EXE/MEM and similar) in the pipelined CPU. It carries a control-bit vector, two data words and a destination register number from one stage to the next. Unlike a plain clocked stage register, it adds a valid/ready handshake with a two-entry skid buffer, a synchronous flush that inserts bubbles, and gating of control bits so a bubble can never write memory or the register file.

## Interface
Parameters:
- DW, 32, width of each data word (alu result, b operand)
- NCTL, 3, number of control bits (e.g. wreg, m2reg, wmem)
- RNW, 5, register-number width

Ports:
- clk  in  1  clock; all state changes on rising edge
- clrn  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream stage presents an entry
- in_ready  out  1  block can accept an entry this cycle
- in_ctl  in  NCTL  control bits
- in_alu  in  DW  alu result
- in_b  in  DW  b operand
- in_rn  in  RNW  destination register number
- flush  in  1  synchronous kill of all held entries
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream stage consumes the output entry
- out_ctl  out  NCTL  control bits, forced to 0 when out_valid=0
- out_alu  out  DW  alu result
- out_b  out  DW  b operand
- out_rn  out  RNW  destination register number
- count  out  2  occupancy, 0..2

## Operation
- Storage consists of a main entry M, which drives the outputs, and a skid entry S. Each entry holds ctl, alu, b and rn.
- States (encoded as count): EMPTY=0, ONE=1 (M valid), TWO=2 (M and S valid).
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- in_ready = (state != TWO). It is decoded from registered state only, with no combinational path from out_ready or in_valid.
- Transitions (no flush):
  - EMPTY: accept -> M<=in, ONE.
  - ONE: accept&consume -> M<=in, stay ONE. Accept&!consume -> S<=in, TWO. !accept&consume -> EMPTY. Otherwise hold.
  - TWO: consume -> M<=S, ONE. Otherwise hold. No accept is possible in TWO.
- Order is strictly FIFO. The entry in S always follows M.
- flush=1 overrides all other inputs:
  - Next state is EMPTY, and stored ctl fields in M and S are cleared to 0.
  - An entry accepted in the same cycle (in_ready=1, in_valid=1) is discarded.
  - A consume in the same cycle still counts as delivered downstream.
  - alu, b and rn fields hold their previous values.
- out_valid = (state != EMPTY). out_ctl = M.ctl & {NCTL{out_valid}}.
- out_alu, out_b and out_rn come directly from M registers. Their value is don't-care when out_valid=0, but they are deterministic: they hold the last value.
- count reflects the current state.

## Timing
- Reset (clrn=0, asynchronous): state EMPTY and all M/S fields 0. Resulting outputs: out_valid=0, out_ctl=0, out_alu=0, out_b=0, out_rn=0, count=0, in_ready=1.
- Reset may assert mid-transfer. All held entries are lost immediately, without waiting for a clock edge.
- Latency: an entry accepted at edge k is visible on the outputs after edge k, i.e. one cycle, when the block is EMPTY or ONE with consume.
- Throughput: one entry per cycle sustained while out_ready=1.
- Backpressure: after out_ready drops, at most one further entry is absorbed (into S). in_ready deasserts the cycle after S fills and reasserts the cycle after the first consume in TWO.
- All outputs are registered or decoded only from registered state. There are no input-to-output combinational paths except none.

## Test plan
- Reset: drive clrn=0 mid-stream with count=2 -> out_valid=0, out_ctl=3'b000, out_alu=0, count=0 and in_ready=1 immediately. After release, the first accepted entry appears one cycle later.
- Streaming: out_ready=1, in_valid=1 with alu=1,2,3,4 on consecutive cycles -> out_alu=1,2,3,4 on the following cycles, out_valid steady at 1, count=1.
- Backpressure: stream alu=10,11,12 with out_ready=0 from the cycle 10 lands -> 10 held in M, 11 in S, count=2, in_ready=0, and 12 is held upstream. Raise out_ready -> outputs 10,11,12 in order, with no loss or duplication.
- Flush with full buffer: count=2 and ctl=3'b111 on both entries, assert flush -> next cycle out_valid=0, out_ctl=0, count=0, in_ready=1.
- Flush plus simultaneous accept: count=1, in_valid=1 with alu=0x55, flush=1 -> the entry is dropped, count=0. The next cycle out_valid=0 and no 0x55 ever appears.
- Parameter sweep: instantiate with DW=64, NCTL=5, RNW=6 and repeat streaming and backpressure -> full-width values such as 0xFFFF_FFFF_0000_0001 and rn=63 are transferred intact.
